// File: rtl/fetch_redirect_scheduler.sv
// Picks one PC redirect per cycle (INT > RW > RN > BP) and holds it until the
// next-PC stage accepts it; optionally bubbles fetch after INT/RW retires.
module fetch_redirect_scheduler #(
  parameter int PC_WIDTH     = 32,
  parameter int HIST_WIDTH   = 10,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  int_req,
  input  logic [PC_WIDTH-1:0]   int_pc,
  input  logic                  rw_req,
  input  logic [PC_WIDTH-1:0]   rw_pc,
  input  logic [HIST_WIDTH-1:0] rw_hist,
  input  logic                  rn_req,
  input  logic [PC_WIDTH-1:0]   rn_pc,
  input  logic [HIST_WIDTH-1:0] rn_hist,
  input  logic                  bp_req,
  input  logic [PC_WIDTH-1:0]   bp_pc,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [HIST_WIDTH-1:0] redirect_hist,
  output logic                  redirect_hist_we,
  output logic [1:0]            redirect_src,
  output logic                  fetch_bubble,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam int SW = CNT_WIDTH + 3;

  state_t                state, stateNxt;
  logic [PC_WIDTH-1:0]   pendPc, pcNxt, winPc;
  logic [HIST_WIDTH-1:0] pendHist, histNxt, winHist;
  logic [1:0]            pendSrc, srcNxt, winSrc;
  logic [DW-1:0]         drainCnt, cntNxt;
  logic [CNT_WIDTH-1:0]  dropCnt, dropNxt;
  logic [2:0]            reqNum, dropInc;
  logic [SW-1:0]         dropSum;
  logic                  anyReq, winCrit, capture;

  always_comb begin
    reqNum  = 3'(int_req) + 3'(rw_req) + 3'(rn_req) + 3'(bp_req);
    anyReq  = int_req | rw_req | rn_req | bp_req;
    winCrit = int_req | rw_req;
    winSrc  = 2'd0;
    winPc   = bp_pc;
    winHist = '0;
    if (int_req) begin
      winSrc = 2'd3;
      winPc  = int_pc;
    end else if (rw_req) begin
      winSrc  = 2'd2;
      winPc   = rw_pc;
      winHist = rw_hist;
    end else if (rn_req) begin
      winSrc  = 2'd1;
      winPc   = rn_pc;
      winHist = rn_hist;
    end
  end

  always_comb begin
    stateNxt = state;
    pcNxt    = pendPc;
    histNxt  = pendHist;
    srcNxt   = pendSrc;
    cntNxt   = drainCnt;
    dropInc  = 3'd0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        capture = anyReq;
        if (anyReq) dropInc = reqNum - 3'd1;
      end
      HOLD: begin
        if (!redirect_ready) begin
          // a replace loses the old entry, a reject loses the newcomer
          capture = anyReq && (winSrc >= pendSrc);
          dropInc = reqNum;
        end else if (pendSrc[1]) begin
          if (winCrit) begin
            capture = 1'b1;
            dropInc = reqNum - 3'd1;
          end else begin
            dropInc  = reqNum;
            cntNxt   = DRAIN_INIT;
            stateNxt = (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
          end
        end else if (anyReq) begin
          capture = 1'b1;
          dropInc = reqNum - 3'd1;
        end else begin
          stateNxt = IDLE;
        end
      end
      DRAIN: begin
        if (winCrit) begin
          capture = 1'b1;
          dropInc = reqNum - 3'd1;
        end else begin
          dropInc = reqNum;
          if (drainCnt == DW'(1)) stateNxt = IDLE;
          else cntNxt = drainCnt - DW'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (capture) begin
      stateNxt = HOLD;
      pcNxt    = winPc;
      histNxt  = winHist;
      srcNxt   = winSrc;
      cntNxt   = '0;
    end
    dropSum = {3'b000, dropCnt} + SW'(dropInc);
    dropNxt = (|dropSum[SW-1:CNT_WIDTH]) ? '1 : dropSum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pendPc   <= '0;
      pendHist <= '0;
      pendSrc  <= '0;
      drainCnt <= '0;
      dropCnt  <= '0;
    end else begin
      state    <= stateNxt;
      pendPc   <= pcNxt;
      pendHist <= histNxt;
      pendSrc  <= srcNxt;
      drainCnt <= cntNxt;
      dropCnt  <= dropNxt;
    end
  end

  assign redirect_valid   = (state == HOLD);
  assign redirect_pc      = pendPc;
  assign redirect_hist    = pendHist;
  assign redirect_src     = pendSrc;
  assign redirect_hist_we = redirect_valid && (pendSrc[1] ^ pendSrc[0]);
  assign fetch_bubble     = (state == DRAIN);
  assign drop_count       = dropCnt;

endmodule

// File: doc/fetch_redirect_scheduler.md
Name: fetch_redirect_scheduler

Overview:
- Arbitrates all PC-redirect sources feeding the next-PC stage: interrupt, writeback/commit recovery, rename recovery, branch-predictor taken redirect.
- Registers a single winning redirect (PC plus global-history restore) and holds it until the next-PC stage accepts it under stall.
- After a pipeline-wide flush, optionally gates fetch for a fixed bubble window.

Parameters:
PC_WIDTH, 32, width of PC fields
HIST_WIDTH, 10, width of branch global history
DRAIN_CYCLES, 2, fetch-bubble cycles after an INT/RW redirect retires; 0 disables DRAIN
CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
int_req  in  1  interrupt redirect request
int_pc  in  PC_WIDTH  interrupt target
rw_req  in  1  writeback/commit recovery request
rw_pc  in  PC_WIDTH  recovered PC
rw_hist  in  HIST_WIDTH  recovered history
rn_req  in  1  rename recovery request
rn_pc  in  PC_WIDTH  recovered PC
rn_hist  in  HIST_WIDTH  recovered history
bp_req  in  1  predicted-taken redirect
bp_pc  in  PC_WIDTH  BTB/RAS target
redirect_ready  in  1  next-PC stage accepts redirect this cycle (low when stalled)
redirect_valid  out  1  pending redirect present
redirect_pc  out  PC_WIDTH  redirect target
redirect_hist  out  HIST_WIDTH  history to restore
redirect_hist_we  out  1  restore history (RW/RN only)
redirect_src  out  2  0=BP 1=RN 2=RW 3=INT
fetch_bubble  out  1  suppress fetch (DRAIN)
drop_count  out  CNT_WIDTH  saturating count of discarded requests

Behaviour:
- Reset (rst_n low, async): state IDLE, all outputs 0, counters 0. Takes effect mid-handshake; the pending redirect is lost.
- Priority INT(3) > RW(2) > RN(1) > BP(0). Same-cycle requests: the highest wins. Every other asserted request increments drop_count by 1 each.
- Outputs are registered. An accepted request is visible on redirect_* the following cycle (1-cycle latency). There is no combinational path from requests to outputs.
- Handshake: redirect retires on a cycle with redirect_valid && redirect_ready.
- State IDLE (redirect_valid=0):
  - Winner captured → HOLD.
  - No request → IDLE.
- State HOLD (redirect_valid=1):
  - Incoming winner with src >= pending src replaces the pending contents; equal priority means newer wins. The replaced entry counts as one drop.
  - Incoming winner with lower src is dropped and counted.
  - Same cycle as retirement: the pending entry is considered gone.
    - If the retiring src is INT/RW, any incoming RN/BP is dropped and counted. Incoming INT/RW is captured → HOLD.
    - Otherwise the incoming winner is captured → HOLD.
  - Retire with no capture:
    - src INT/RW and DRAIN_CYCLES>0 → DRAIN, counter=DRAIN_CYCLES.
    - Otherwise → IDLE.
- State DRAIN (fetch_bubble=1, redirect_valid=0):
  - Counter decrements each cycle; at 1 → IDLE next cycle. fetch_bubble is high exactly DRAIN_CYCLES cycles.
  - INT/RW request: captured, counter abandoned → HOLD, fetch_bubble low next cycle.
  - RN/BP: dropped and counted.
- redirect_hist_we=1 only when redirect_src ∈ {RW,RN} and redirect_valid.
- redirect_hist=0 for INT/BP.
- drop_count saturates at all-ones and never wraps.
- PC values pass through unmodified; no alignment or arithmetic.

Test Plan:
1. Reset then bp_req=1, bp_pc=0x1000 for one cycle, ready=1 → next cycle valid=1, pc=0x1000, src=0, hist_we=0. The following cycle valid=0, state IDLE.
2. Simultaneous rn_req (pc 0x2000, hist 0x15) and bp_req → src=1, pc=0x2000, hist=0x15, hist_we=1, drop_count=1.
3. ready=0, rn_req (0x2000) captured, then bp_req next cycle, then rw_req (0x3000, hist 0x2A) → BP dropped. RW replaces RN; redirect shows 0x3000 src=2, drop_count=2. Raise ready → retires, fetch_bubble=1 for exactly 2 cycles, then IDLE.
4. During DRAIN: bp_req → dropped (drop_count+1). int_req (0x8000) in second DRAIN cycle → fetch_bubble=0 next cycle, valid=1, src=3, hist_we=0.
5. HOLD with RW retiring (ready=1) while rn_req asserted same cycle → RN dropped, DRAIN entered. With DRAIN_CYCLES=0 → IDLE directly, fetch_bubble never asserted.
6. Force drop_count to all-ones via repeated drops → stays 0xFFFF. Assert rst_n=0 mid-HOLD asynchronously → valid, fetch_bubble, drop_count all 0 before the next clk edge.
